// File: rtl/mc_control_fsm_if.sv
// Control/status bundle between the RV32I multicycle control FSM and its datapath.
// The FSM side is the master (drives controls); the datapath side is the slave.
interface mc_control_fsm_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       trap_ack;
  logic       AdrSrc;
  logic       IRWrite;
  logic       PCUpdate;
  logic       RegWrite;
  logic       MemWrite;
  logic       Branch;
  logic       MemReq;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic [1:0] ResultSrc;
  logic       Trap;
  logic [1:0] TrapCause;
  logic [3:0] FSMState;

  modport master (
    input  opcode, mem_ready, trap_ack,
    output AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, MemReq,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Trap, TrapCause, FSMState
  );

  modport slave (
    output opcode, mem_ready, trap_ack,
    input  AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, MemReq,
           ALUSrcA, ALUSrcB, ALUOp, ResultSrc, Trap, TrapCause, FSMState
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: 16-state Moore FSM with ready handshake on memory
// states, a stall watchdog and an illegal-opcode trap.
module mc_control_fsm #(
  parameter int MEM_HANDSHAKE   = 1,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input logic              clk,
  input logic              reset,
  mc_control_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH      = 4'd0,
    S_DECODE     = 4'd1,
    S_EXECUTER   = 4'd2,
    S_UNCONDJUMP = 4'd3,
    S_EXECUTEI   = 4'd4,
    S_MEMADR     = 4'd5,
    S_ALUWB      = 4'd6,
    S_MEMWRITE   = 4'd7,
    S_MEMREAD    = 4'd8,
    S_MEMWB      = 4'd9,
    S_BRANCH     = 4'd10,
    S_JALR       = 4'd11,
    S_LUI        = 4'd12,
    S_AUIPC      = 4'd13,
    S_TRAP       = 4'd14,
    S_LINK       = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // A disabled watchdog still keeps a 1-bit counter so no zero-width vector exists.
  localparam int WCW       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int WD_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [WCW-1:0] WD_LAST = WCW'(WD_LAST_I);
  localparam logic [WCW-1:0] WD_ONE  = WCW'(1);
  localparam logic [WCW-1:0] WD_ZERO = WCW'(0);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WCW-1:0]   wait_cnt_r;
  logic [WCW-1:0]   wait_cnt_nxt_s;
  logic [1:0]       trap_cause_r;
  logic [1:0]       trap_cause_nxt_s;
  logic             rdy_s;
  logic             mem_wait_state_s;
  logic             wd_expire_s;

  logic             adr_src_s;
  logic             ir_write_s;
  logic             pc_update_s;
  logic             reg_write_s;
  logic             mem_write_s;
  logic             branch_s;
  logic             mem_req_s;
  logic [1:0]       alu_src_a_s;
  logic [1:0]       alu_src_b_s;
  logic [2:0]       alu_op_s;
  logic [1:0]       result_src_s;
  logic             trap_s;
  logic [1:0]       trap_cause_out_s;
  logic [3:0]       fsm_state_s;

  // Unknown opcodes map to S_TRAP; DECODE then decides between trapping and skipping.
  function automatic state_t decode_target(input logic [6:0] op);
    case (op)
      OP_R:      return S_EXECUTER;
      OP_I:      return S_EXECUTEI;
      OP_LOAD:   return S_MEMADR;
      OP_STORE:  return S_MEMADR;
      OP_BRANCH: return S_BRANCH;
      OP_JAL:    return S_UNCONDJUMP;
      OP_JALR:   return S_JALR;
      OP_LUI:    return S_LUI;
      OP_AUIPC:  return S_AUIPC;
      default:   return S_TRAP;
    endcase
  endfunction

  assign rdy_s            = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
  assign mem_wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMREAD) ||
                            (state_r == S_MEMWRITE);
  assign wd_expire_s      = (TIMEOUT_CYCLES > 0) && mem_wait_state_s && !rdy_s &&
                            (wait_cnt_r == WD_LAST);

  // Next-state selection and trap cause capture on entry to TRAP.
  always_comb begin
    state_nxt_s      = state_r;
    trap_cause_nxt_s = trap_cause_r;
    case (state_r)
      S_FETCH: begin
        if (rdy_s) begin
          state_nxt_s = S_DECODE;
        end else if (wd_expire_s) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = CAUSE_TIMEOUT;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (decode_target(bus.opcode) != S_TRAP) begin
          state_nxt_s = decode_target(bus.opcode);
        end else if (TRAP_ON_ILLEGAL != 0) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = CAUSE_ILLEGAL;
        end else begin
          state_nxt_s = S_FETCH;
        end
      end
      S_MEMADR: begin
        if (bus.opcode == OP_STORE) begin
          state_nxt_s = S_MEMWRITE;
        end else begin
          state_nxt_s = S_MEMREAD;
        end
      end
      S_MEMREAD: begin
        if (rdy_s) begin
          state_nxt_s = S_MEMWB;
        end else if (wd_expire_s) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = CAUSE_TIMEOUT;
        end else begin
          state_nxt_s = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (rdy_s) begin
          state_nxt_s = S_FETCH;
        end else if (wd_expire_s) begin
          state_nxt_s      = S_TRAP;
          trap_cause_nxt_s = CAUSE_TIMEOUT;
        end else begin
          state_nxt_s = S_MEMWRITE;
        end
      end
      S_EXECUTER, S_EXECUTEI, S_LUI, S_AUIPC, S_UNCONDJUMP, S_LINK: begin
        state_nxt_s = S_ALUWB;
      end
      S_ALUWB, S_MEMWB, S_BRANCH: begin
        state_nxt_s = S_FETCH;
      end
      S_JALR: begin
        state_nxt_s = S_LINK;
      end
      S_TRAP: begin
        if (bus.trap_ack) begin
          state_nxt_s = S_FETCH;
        end else begin
          state_nxt_s = S_TRAP;
        end
      end
      default: begin
        state_nxt_s = S_FETCH;
      end
    endcase
  end

  // Watchdog counter: counts consecutive not-ready cycles, restarts on any state change.
  always_comb begin
    wait_cnt_nxt_s = wait_cnt_r;
    if (TIMEOUT_CYCLES == 0) begin
      wait_cnt_nxt_s = WD_ZERO;
    end else if (state_nxt_s != state_r) begin
      wait_cnt_nxt_s = WD_ZERO;
    end else if (mem_wait_state_s && !rdy_s) begin
      wait_cnt_nxt_s = wait_cnt_r + WD_ONE;
    end else begin
      wait_cnt_nxt_s = wait_cnt_r;
    end
  end

  // State, watchdog and trap cause registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_FETCH;
      wait_cnt_r   <= WD_ZERO;
      trap_cause_r <= CAUSE_NONE;
    end else begin
      state_r      <= state_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      trap_cause_r <= trap_cause_nxt_s;
    end
  end

  // Moore output decode; reset forces every control low so an aborted access stops at once.
  always_comb begin
    adr_src_s        = 1'b0;
    ir_write_s       = 1'b0;
    pc_update_s      = 1'b0;
    reg_write_s      = 1'b0;
    mem_write_s      = 1'b0;
    branch_s         = 1'b0;
    mem_req_s        = 1'b0;
    alu_src_a_s      = 2'b00;
    alu_src_b_s      = 2'b00;
    alu_op_s         = 3'b000;
    result_src_s     = 2'b00;
    trap_s           = 1'b0;
    trap_cause_out_s = 2'b00;
    fsm_state_s      = 4'd0;
    if (reset) begin
      fsm_state_s = 4'd0;
    end else begin
      fsm_state_s = state_r;
      case (state_r)
        S_FETCH: begin
          mem_req_s    = 1'b1;
          alu_src_b_s  = 2'b10;
          result_src_s = 2'b10;
          ir_write_s   = rdy_s;
          pc_update_s  = rdy_s;
        end
        S_DECODE: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b01;
        end
        S_EXECUTER: begin
          alu_src_a_s = 2'b10;
          alu_op_s    = 3'b010;
        end
        S_EXECUTEI: begin
          alu_src_a_s = 2'b10;
          alu_src_b_s = 2'b01;
          alu_op_s    = 3'b011;
        end
        S_LUI: begin
          alu_src_a_s = 2'b11;
          alu_src_b_s = 2'b01;
        end
        S_AUIPC: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a_s = 2'b10;
          alu_src_b_s = 2'b01;
        end
        S_MEMREAD: begin
          mem_req_s = 1'b1;
          adr_src_s = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req_s   = 1'b1;
          adr_src_s   = 1'b1;
          mem_write_s = 1'b1;
        end
        S_MEMWB: begin
          result_src_s = 2'b01;
          reg_write_s  = 1'b1;
        end
        S_ALUWB: begin
          reg_write_s = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_s = 2'b10;
          alu_op_s    = 3'b001;
          branch_s    = 1'b1;
        end
        S_UNCONDJUMP: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b10;
          pc_update_s = 1'b1;
        end
        S_JALR: begin
          alu_src_a_s  = 2'b10;
          alu_src_b_s  = 2'b01;
          result_src_s = 2'b10;
          pc_update_s  = 1'b1;
        end
        S_LINK: begin
          alu_src_a_s = 2'b01;
          alu_src_b_s = 2'b10;
        end
        S_TRAP: begin
          trap_s           = 1'b1;
          trap_cause_out_s = trap_cause_r;
        end
        default: begin
          fsm_state_s = state_r;
        end
      endcase
    end
  end

  assign bus.AdrSrc    = adr_src_s;
  assign bus.IRWrite   = ir_write_s;
  assign bus.PCUpdate  = pc_update_s;
  assign bus.RegWrite  = reg_write_s;
  assign bus.MemWrite  = mem_write_s;
  assign bus.Branch    = branch_s;
  assign bus.MemReq    = mem_req_s;
  assign bus.ALUSrcA   = alu_src_a_s;
  assign bus.ALUSrcB   = alu_src_b_s;
  assign bus.ALUOp     = alu_op_s;
  assign bus.ResultSrc = result_src_s;
  assign bus.Trap      = trap_s;
  assign bus.TrapCause = trap_cause_out_s;
  assign bus.FSMState  = fsm_state_s;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: three parameter sets, each checked cycle by cycle against
// expected state traces built per instruction class from the opcode and stall plan.
module tb_mc_control_fsm;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [3:0] st;
    logic [6:0] op;
    logic       mr;
    logic       ack;
    logic       rdy;
    logic [1:0] cause;
  } ent_t;

  logic       clk;
  logic [2:0] rst_v;
  int         n_tests;
  int         n_fail;
  ent_t       q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mc_control_fsm_if if0();
  mc_control_fsm_if if1();
  mc_control_fsm_if if2();

  mc_control_fsm #(.MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(0), .TRAP_ON_ILLEGAL(1))
    dut0 (.clk(clk), .reset(rst_v[0]), .bus(if0));
  mc_control_fsm #(.MEM_HANDSHAKE(1), .TIMEOUT_CYCLES(3), .TRAP_ON_ILLEGAL(1))
    dut1 (.clk(clk), .reset(rst_v[1]), .bus(if1));
  mc_control_fsm #(.MEM_HANDSHAKE(0), .TIMEOUT_CYCLES(3), .TRAP_ON_ILLEGAL(0))
    dut2 (.clk(clk), .reset(rst_v[2]), .bus(if2));

  function automatic int cfg_mh(input int sel);
    return (sel == 2) ? 0 : 1;
  endfunction
  function automatic int cfg_to(input int sel);
    return (sel == 0) ? 0 : 3;
  endfunction
  function automatic int cfg_toi(input int sel);
    return (sel == 2) ? 0 : 1;
  endfunction

  function automatic int op_class(input logic [6:0] op);
    case (op)
      OP_R:      return 0;
      OP_I:      return 1;
      OP_LOAD:   return 2;
      OP_STORE:  return 3;
      OP_BRANCH: return 4;
      OP_JAL:    return 5;
      OP_JALR:   return 6;
      OP_LUI:    return 7;
      OP_AUIPC:  return 8;
      default:   return 9;
    endcase
  endfunction

  function automatic logic [6:0] rand_op();
    int r = $urandom_range(0, 9);
    logic [6:0] o;
    case (r)
      0: o = OP_R;      1: o = OP_I;     2: o = OP_LOAD;
      3: o = OP_STORE;  4: o = OP_BRANCH; 5: o = OP_JAL;
      6: o = OP_JALR;   7: o = OP_LUI;    8: o = OP_AUIPC;
      default: begin
        o = 7'($urandom);
        if (op_class(o) != 9) o = 7'b1111111;
      end
    endcase
    return o;
  endfunction

  // Expected control word for one cycle, straight from the per-state output table.
  function automatic logic [22:0] exp_vec(input ent_t e);
    logic adr, irw, pcu, rw, mw, br, mrq, tr;
    logic [1:0] a, b, rs, tc;
    logic [2:0] alu;
    {adr, irw, pcu, rw, mw, br, mrq, tr} = 8'd0;
    a = 2'b00; b = 2'b00; rs = 2'b00; tc = 2'b00; alu = 3'b000;
    case (e.st)
      4'd0:  begin mrq = 1'b1; b = 2'b10; rs = 2'b10; irw = e.rdy; pcu = e.rdy; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; alu = 3'b010; end
      4'd3:  begin a = 2'b01; b = 2'b10; pcu = 1'b1; end
      4'd4:  begin a = 2'b10; b = 2'b01; alu = 3'b011; end
      4'd5:  begin a = 2'b10; b = 2'b01; end
      4'd6:  begin rw = 1'b1; end
      4'd7:  begin mrq = 1'b1; adr = 1'b1; mw = 1'b1; end
      4'd8:  begin mrq = 1'b1; adr = 1'b1; end
      4'd9:  begin rs = 2'b01; rw = 1'b1; end
      4'd10: begin a = 2'b10; alu = 3'b001; br = 1'b1; end
      4'd11: begin a = 2'b10; b = 2'b01; rs = 2'b10; pcu = 1'b1; end
      4'd12: begin a = 2'b11; b = 2'b01; end
      4'd13: begin a = 2'b01; b = 2'b01; end
      4'd14: begin tr = 1'b1; tc = e.cause; end
      default: begin a = 2'b01; b = 2'b10; end
    endcase
    return {adr, irw, pcu, rw, mw, br, mrq, a, b, alu, rs, tr, tc, e.st};
  endfunction

  function automatic logic [22:0] sample(input int sel);
    case (sel)
      0: return {if0.AdrSrc, if0.IRWrite, if0.PCUpdate, if0.RegWrite, if0.MemWrite, if0.Branch,
                 if0.MemReq, if0.ALUSrcA, if0.ALUSrcB, if0.ALUOp, if0.ResultSrc, if0.Trap,
                 if0.TrapCause, if0.FSMState};
      1: return {if1.AdrSrc, if1.IRWrite, if1.PCUpdate, if1.RegWrite, if1.MemWrite, if1.Branch,
                 if1.MemReq, if1.ALUSrcA, if1.ALUSrcB, if1.ALUOp, if1.ResultSrc, if1.Trap,
                 if1.TrapCause, if1.FSMState};
      default: return {if2.AdrSrc, if2.IRWrite, if2.PCUpdate, if2.RegWrite, if2.MemWrite,
                 if2.Branch, if2.MemReq, if2.ALUSrcA, if2.ALUSrcB, if2.ALUOp, if2.ResultSrc,
                 if2.Trap, if2.TrapCause, if2.FSMState};
    endcase
  endfunction

  task automatic drive(input int sel, input logic [6:0] op, input logic mr, input logic ack);
    case (sel)
      0: begin if0.opcode = op; if0.mem_ready = mr; if0.trap_ack = ack; end
      1: begin if1.opcode = op; if1.mem_ready = mr; if1.trap_ack = ack; end
      default: begin if2.opcode = op; if2.mem_ready = mr; if2.trap_ack = ack; end
    endcase
  endtask

  task automatic push(input logic [3:0] st, input logic [6:0] op, input logic mr,
                      input logic ack, input logic rdy, input logic [1:0] cause);
    ent_t e;
    e.st = st; e.op = op; e.mr = mr; e.ack = ack; e.rdy = rdy; e.cause = cause;
    q.push_back(e);
  endtask

  task automatic push_plain(input logic [3:0] st, input logic [6:0] op);
    push(st, op, 1'($urandom), 1'($urandom), 1'b0, 2'b00);
  endtask

  task automatic push_idle(input int sel);
    push(4'd0, 7'($urandom), 1'b0, 1'($urandom), (cfg_mh(sel) == 0), 2'b00);
  endtask

  // A memory-facing state that sees k not-ready cycles before completing.
  task automatic mem_phase(input int sel, input logic [3:0] st, input logic [6:0] op,
                           input bit rand_op_en, input int k, output bit tout);
    logic [6:0] o;
    int to;
    to = cfg_to(sel);
    tout = 1'b0;
    o = rand_op_en ? 7'($urandom) : op;
    if (cfg_mh(sel) == 0) begin
      push(st, o, 1'($urandom), 1'($urandom), 1'b1, 2'b00);
    end else if (to > 0 && k >= to) begin
      for (int j = 0; j < to; j++) begin
        o = rand_op_en ? 7'($urandom) : op;
        push(st, o, 1'b0, 1'($urandom), 1'b0, 2'b00);
      end
      tout = 1'b1;
    end else begin
      for (int j = 0; j < k; j++) begin
        o = rand_op_en ? 7'($urandom) : op;
        push(st, o, 1'b0, 1'($urandom), 1'b0, 2'b00);
      end
      o = rand_op_en ? 7'($urandom) : op;
      push(st, o, 1'b1, 1'($urandom), 1'b1, 2'b00);
    end
  endtask

  task automatic trap_phase(input logic [1:0] cause, input logic [6:0] op, input int kt);
    for (int j = 0; j < kt; j++) push(4'd14, op, 1'($urandom), 1'b0, 1'b0, cause);
    push(4'd14, op, 1'($urandom), 1'b1, 1'b0, cause);
  endtask

  // Expected cycle trace of one instruction, starting in FETCH.
  task automatic build_instr(input int sel, input logic [6:0] op, input int kf,
                             input int km, input int kt);
    bit tout;
    mem_phase(sel, 4'd0, op, 1'b1, kf, tout);
    if (tout) begin
      trap_phase(2'b10, op, kt);
      return;
    end
    push_plain(4'd1, op);
    case (op_class(op))
      0: begin push_plain(4'd2, op); push_plain(4'd6, op); end
      1: begin push_plain(4'd4, op); push_plain(4'd6, op); end
      2: begin
        push_plain(4'd5, op);
        mem_phase(sel, 4'd8, op, 1'b0, km, tout);
        if (tout) trap_phase(2'b10, op, kt);
        else push_plain(4'd9, op);
      end
      3: begin
        push_plain(4'd5, op);
        mem_phase(sel, 4'd7, op, 1'b0, km, tout);
        if (tout) trap_phase(2'b10, op, kt);
      end
      4: push_plain(4'd10, op);
      5: begin push_plain(4'd3, op); push_plain(4'd6, op); end
      6: begin push_plain(4'd11, op); push_plain(4'd15, op); push_plain(4'd6, op); end
      7: begin push_plain(4'd12, op); push_plain(4'd6, op); end
      8: begin push_plain(4'd13, op); push_plain(4'd6, op); end
      default: if (cfg_toi(sel) != 0) trap_phase(2'b01, op, kt);
    endcase
  endtask

  task automatic start(input int sel);
    rst_v = 3'b111;
    drive(sel, 7'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_v[sel] = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    rst_v = 3'b111;
    for (int s = 0; s < 3; s++) drive(s, OP_R, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      obs = sample(s);
      n_tests++;
      if (obs !== 23'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want %h", s, obs, 23'd0);
      end
    end
  endtask

  task automatic test_rtype();
    logic [22:0] obs, expv;
    start(0); q.delete();
    build_instr(0, OP_R, 0, 0, 0);
    push_idle(0);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive(0, q[i].op, q[i].mr, q[i].ack);
      #1;
      obs = sample(0); expv = exp_vec(q[i]);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL rtype cyc %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_load_stall();
    logic [22:0] obs, expv;
    start(0); q.delete();
    build_instr(0, OP_LOAD, 0, 2, 0);
    push_idle(0);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive(0, q[i].op, q[i].mr, q[i].ack);
      #1;
      obs = sample(0); expv = exp_vec(q[i]);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL load_stall cyc %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_jalr();
    logic [22:0] obs, expv;
    start(0); q.delete();
    build_instr(0, OP_JALR, 0, 0, 0);
    push_idle(0);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive(0, q[i].op, q[i].mr, q[i].ack);
      #1;
      obs = sample(0); expv = exp_vec(q[i]);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL jalr cyc %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_illegal();
    logic [22:0] obs, expv;
    int sel;
    for (int k = 0; k < 2; k++) begin
      sel = k * 2;
      start(sel); q.delete();
      build_instr(sel, 7'b1111111, 0, 0, 3);
      push_idle(sel);
      for (int i = 0; i < q.size(); i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        drive(sel, q[i].op, q[i].mr, q[i].ack);
        #1;
        obs = sample(sel); expv = exp_vec(q[i]);
        n_tests++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL illegal dut%0d cyc %0d: got %h want %h", sel, i, obs, expv);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic [22:0] obs, expv;
    start(1); q.delete();
    build_instr(1, OP_R, 5, 0, 2);
    build_instr(1, OP_LOAD, 2, 3, 1);
    build_instr(1, 7'b1111111, 0, 0, 0);
    build_instr(1, OP_STORE, 0, 2, 0);
    build_instr(1, OP_STORE, 1, 4, 0);
    push_idle(1);
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive(1, q[i].op, q[i].mr, q[i].ack);
      #1;
      obs = sample(1); expv = exp_vec(q[i]);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL timeout cyc %0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    logic [22:0] obs, expv;
    ent_t e;
    start(0); q.delete();
    build_instr(0, OP_STORE, 0, 5, 0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      drive(0, q[i].op, q[i].mr, q[i].ack);
      #1;
      obs = sample(0); expv = exp_vec(q[i]);
      n_tests++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL midwrite cyc %0d: got %h want %h", i, obs, expv);
      end
    end
    rst_v[0] = 1'b1;
    #1;
    n_tests++;
    if (if0.MemWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL midwrite_memwrite: got %b want 0", if0.MemWrite);
    end
    obs = sample(0);
    n_tests++;
    if (obs !== 23'd0) begin
      n_fail++;
      $display("FAIL midwrite_in_reset: got %h want %h", obs, 23'd0);
    end
    @(negedge clk);
    rst_v[0] = 1'b0;
    drive(0, OP_R, 1'b0, 1'b0);
    #1;
    e.st = 4'd0; e.op = OP_R; e.mr = 1'b0; e.ack = 1'b0; e.rdy = 1'b0; e.cause = 2'b00;
    obs = sample(0); expv = exp_vec(e);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL midwrite_release: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_random();
    logic [22:0] obs, expv;
    for (int sel = 0; sel < 3; sel++) begin
      start(sel); q.delete();
      for (int n = 0; n < 30; n++) begin
        build_instr(sel, rand_op(), $urandom_range(0, 4), $urandom_range(0, 4),
                    $urandom_range(0, 3));
      end
      for (int i = 0; i < q.size(); i++) begin
        if (i > 0) begin @(posedge clk); #1; end
        drive(sel, q[i].op, q[i].mr, q[i].ack);
        #1;
        obs = sample(sel); expv = exp_vec(q[i]);
        n_tests++;
        if (obs !== expv) begin
          n_fail++;
          $display("FAIL random dut%0d cyc %0d: got %h want %h", sel, i, obs, expv);
        end
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_v   = 3'b111;
    for (int s = 0; s < 3; s++) drive(s, 7'd0, 1'b0, 1'b0);
    test_reset();
    test_rtype();
    test_load_stall();
    test_jalr();
    test_illegal();
    test_timeout();
    test_reset_midwrite();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Parametrised multicycle control unit for the RV32I core: a 16-state Moore FSM that sequences fetch, decode, execute, memory and writeback for the full RV32I base opcode set, including JALR, LUI and AUIPC. Every memory access uses a ready handshake, a watchdog covers stalled accesses, and illegal opcodes trap. It drives the datapath multiplexers, write enables and the ALU decoder.

## Interface
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready is treated as constant 1.
- TIMEOUT_CYCLES, 0: consecutive not-ready cycles before a timeout trap; 0 disables the watchdog.
- TRAP_ON_ILLEGAL, 1: 1 = an unknown opcode enters TRAP; 0 = it returns to FETCH, skipping the instruction.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  7  instruction[6:0] from the IR, valid from DECODE onward.
- mem_ready  in  1  memory has completed the current request this cycle.
- trap_ack  in  1  releases TRAP.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- IRWrite, PCUpdate, RegWrite, MemWrite, Branch, MemReq  out  1 each.
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero.
- ALUSrcB  out  2  00 = rs2, 01 = immediate, 10 = constant 4.
- ALUOp  out  3  000 = add, 001 = branch compare, 010 = R-type, 011 = I-type.
- ResultSrc  out  2  00 = ALUOut, 01 = read data, 10 = ALU result.
- Trap  out  1; TrapCause  out  2  01 = illegal opcode, 10 = memory timeout.
- FSMState  out  4  current state.

## Operation
- State encodings: FETCH 0, DECODE 1, EXECUTER 2, UNCONDJUMP 3, EXECUTEI 4, MEMADR 5, ALUWB 6, MEMWRITE 7, MEMREAD 8, MEMWB 9, BRANCH 10, JALR 11, LUI 12, AUIPC 13, TRAP 14, LINK 15.
- Opcodes: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Outputs are decoded combinationally from the current state. Any output not listed for a state is 0.
- rdy = mem_ready when MEM_HANDSHAKE = 1, else 1.
- FETCH: MemReq 1, AdrSrc 0, A 00, B 10, ALUOp 000, ResultSrc 10.
  - IRWrite = PCUpdate = rdy.
  - Goes to DECODE when rdy; otherwise stays.
- DECODE: A 01, B 01, ALUOp 000 (branch/JAL target into ALUOut).
  - Next state by opcode: R → EXECUTER, I-ALU → EXECUTEI, load/store → MEMADR, branch → BRANCH, JAL → UNCONDJUMP, JALR → JALR, LUI → LUI, AUIPC → AUIPC.
  - Any other opcode → TRAP (cause 01) or FETCH, per TRAP_ON_ILLEGAL.
- EXECUTER: A 10, B 00, ALUOp 010 → ALUWB.
- EXECUTEI: A 10, B 01, ALUOp 011 → ALUWB.
- LUI: A 11, B 01, ALUOp 000 → ALUWB.
- AUIPC: A 01, B 01, ALUOp 000 → ALUWB.
- MEMADR: A 10, B 01, ALUOp 000 → MEMREAD on load, MEMWRITE on store.
- MEMREAD: MemReq 1, AdrSrc 1 → MEMWB on rdy.
- MEMWRITE: MemReq 1, AdrSrc 1, MemWrite 1 (held until rdy) → FETCH on rdy.
- MEMWB: ResultSrc 01, RegWrite 1 → FETCH.
- ALUWB: ResultSrc 00, RegWrite 1 → FETCH.
- BRANCH: A 10, B 00, ALUOp 001, ResultSrc 00, Branch 1 → FETCH. All funct3 variants are resolved by the ALU decoder and branch logic.
- UNCONDJUMP: A 01, B 10, ALUOp 000, ResultSrc 00, PCUpdate 1 → ALUWB, which writes OldPC+4.
- JALR: A 10, B 01, ALUOp 000, ResultSrc 10, PCUpdate 1 → LINK.
- LINK: A 01, B 10, ALUOp 000 → ALUWB.
- TRAP: Trap 1, TrapCause valid, all other outputs 0 → FETCH on trap_ack.
- TrapCause register: reset 00, loaded on TRAP entry, held until the next trap.
- Watchdog (TIMEOUT_CYCLES > 0):
  - wait_cnt increments each cycle in FETCH, MEMREAD or MEMWRITE while rdy = 0.
  - wait_cnt clears on any state change.
  - If wait_cnt == TIMEOUT_CYCLES-1 and rdy = 0, next state is TRAP with cause 10.
  - Counter width is clog2(TIMEOUT_CYCLES+1).

## Timing
- current_state, wait_cnt and TrapCause update on the rising clk edge.
- While reset is high: state = FETCH, wait_cnt = 0, TrapCause = 00, and every output is forced to 0, including FSMState = 0.
- After reset deasserts, FETCH outputs appear in the same cycle.
- Zero-wait latency per instruction (cycles from FETCH entry to the next FETCH):
  - branch 3.
  - R, I-ALU, store, JAL, LUI, AUIPC 4.
  - load 5, JALR 5.
- Each not-ready cycle in a memory state adds one cycle.
- rdy and a watchdog expiry in the same cycle: rdy wins and the access completes.
- trap_ack outside TRAP is ignored.
- Reset asserted mid-instruction aborts it immediately; no write enable stays high.
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

## Test plan
- R-type 0110011, mem_ready = 1: FSMState sequence 0,1,2,6,0. RegWrite is high only in state 6.
- Load 0000011, mem_ready low for 2 cycles in MEMREAD: sequence 0,1,5,8,8,8,9,0. MemReq and AdrSrc are high in all three state-8 cycles.
- JALR 1100111: sequence 0,1,11,15,6,0. PCUpdate = 1 with ResultSrc 10 in state 11.
- Opcode 1111111 with TRAP_ON_ILLEGAL = 1: TRAP reached with TrapCause 01. It stays there until trap_ack, then returns to FETCH. With TRAP_ON_ILLEGAL = 0: 0,1,0.
- TIMEOUT_CYCLES = 3, mem_ready held 0 in FETCH: 3 cycles in FETCH, then TRAP with cause 10. IRWrite stays 0 throughout.
- Reset pulsed during MEMWRITE: MemWrite drops in the same cycle, and FSMState = 0 after release.
